return_stack_ctrl: RTL

Control-side sequencer for the 64-deep return_stack, which is the responder for push/pop requests.
- Accepts CALL/RET requests from decode/PC logic over a ready/done handshake.
- Drives the stack's stackOP/w inputs and captures the popped return address from the stack's top-of-stack output a.
- Tracks stack depth and raises sticky overflow/underflow flags.

---
 rtl/return_stack_ctrl_if.sv | 30 +++
 rtl/return_stack_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/return_stack_ctrl_if.sv
// Request/response bundle between decode/PC logic, the return-stack sequencer and the
// 64-deep return_stack (stackOP/w out, top-of-stack a in).
interface return_stack_ctrl_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DW    = 7
);
  logic             call_req;
  logic             ret_req;
  logic [WIDTH-1:0] call_addr;
  logic             clr_flags;
  logic [WIDTH-1:0] a;
  logic [1:0]       stackOP;
  logic [WIDTH-1:0] w;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] ret_addr;
  logic [DW-1:0]    depth;
  logic             overflow;
  logic             underflow;

  modport master (
    output call_req, ret_req, call_addr, clr_flags, a,
    input  stackOP, w, ready, done, ret_addr, depth, overflow, underflow
  );

  modport slave (
    input  call_req, ret_req, call_addr, clr_flags, a,
    output stackOP, w, ready, done, ret_addr, depth, overflow, underflow
  );
endinterface

// File: rtl/return_stack_ctrl.sv
// CALL/RET sequencer for the return_stack: IDLE -> PUSH/POP -> DONE, all outputs registered.
// Optional RSCTRL_TAILCALL_EN: simultaneous call+ret does POP then PUSH (replace top).
module return_stack_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned DW    = 7
) (
  input  logic                CLK,
  input  logic                reset,
  return_stack_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StPush, StPop, StDone} state_e;

  localparam logic [1:0] OpNop  = 2'd0;
  localparam logic [1:0] OpPush = 2'd1;
  localparam logic [1:0] OpPop  = 2'd3;

  state_e           state_q, state_d;
  logic [1:0]       stack_op_q, stack_op_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] ret_addr_q, ret_addr_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             tail_q, tail_d;

  logic do_push, do_pop, finish, ovf_set, unf_set;

  always_comb begin
    state_d    = state_q;
    stack_op_d = stack_op_q;
    w_d        = w_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    ret_addr_d = ret_addr_q;
    depth_d    = depth_q;
    tail_d     = tail_q;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    finish     = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.call_req) begin
          w_d = bus.call_addr;
`ifdef RSCTRL_TAILCALL_EN
          if (bus.ret_req) begin
            do_pop = 1'b1;
            tail_d = 1'b1;
          end else begin
            do_push = 1'b1;
          end
`else
          do_push = 1'b1;
`endif
        end else if (bus.ret_req) begin
          do_pop = 1'b1;
        end
      end
      StPop: begin
        // A replace continues with the push half before completing.
        if (tail_q) begin
          do_push = 1'b1;
          tail_d  = 1'b0;
        end else begin
          finish = 1'b1;
        end
      end
      StPush: finish = 1'b1;
      StDone: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (finish) begin
      state_d    = StDone;
      stack_op_d = OpNop;
      done_d     = 1'b1;
    end

    // At full the stack drops its bottom entry, so the push is still issued.
    if (do_push) begin
      state_d    = StPush;
      stack_op_d = OpPush;
      ready_d    = 1'b0;
      if (depth_q == DW'(DEPTH)) begin
        ovf_set = 1'b1;
      end else begin
        depth_d = depth_q + DW'(1);
      end
    end

    if (do_pop) begin
      state_d = StPop;
      ready_d = 1'b0;
      if (depth_q != '0) begin
        ret_addr_d = bus.a;
        stack_op_d = OpPop;
        depth_d    = depth_q - DW'(1);
      end else begin
        ret_addr_d = '0;
        stack_op_d = OpNop;
        unf_set    = 1'b1;
      end
    end

    overflow_d  = ovf_set | (overflow_q & ~bus.clr_flags);
    underflow_d = unf_set | (underflow_q & ~bus.clr_flags);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      stack_op_q  <= OpNop;
      w_q         <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      ret_addr_q  <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      tail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stack_op_q  <= stack_op_d;
      w_q         <= w_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      ret_addr_q  <= ret_addr_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      tail_q      <= tail_d;
    end
  end

  assign bus.stackOP   = stack_op_q;
  assign bus.w         = w_q;
  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.ret_addr  = ret_addr_q;
  assign bus.depth     = depth_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule
